// File: rtl/alu_issuer.sv
// Issues valid/ready commands to a single-cycle-strobe ALU and returns its result.
// Adds opcode checking, carry chaining, a response timeout and a sequence tag.
module alu_issuer #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned TAG_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    input  logic             cmd_chain,
    output logic             valid_in,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    output logic [3:0]       ctl,
    input  logic             valid_out,
    input  logic [WIDTH-1:0] alu,
    input  logic             carry,
    input  logic             zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             stray
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0] OP_MAX = 4'd13;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               cin_q, cin_d;
    logic [3:0]         ctl_q, ctl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_err_q, rsp_err_d;
    logic               stray_q, stray_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            ctl_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            tag_q       <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            ctl_q       <= ctl_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            tag_q       <= tag_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
            stray_q     <= stray_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        ctl_d       = ctl_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        tag_d       = tag_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
        stray_d     = stray_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    a_d   = cmd_a;
                    b_d   = cmd_b;
                    ctl_d = cmd_op;
                    cin_d = cmd_chain ? carry_q : cmd_cin;
                    if (cmd_op > OP_MAX) begin
                        // Illegal opcode never reaches the ALU.
                        state_d     = StResp;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_carry_d = 1'b0;
                        rsp_zero_d  = 1'b0;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                // A result arriving on the terminal count still wins.
                if (valid_out) begin
                    state_d     = StResp;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = alu;
                    rsp_carry_d = carry;
                    rsp_zero_d  = zero;
                    if (ctl_q inside {[4'd3:4'd6]}) begin
                        carry_d = carry;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = StResp;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    rsp_carry_d = 1'b0;
                    rsp_zero_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    tag_d   = tag_q + TAG_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (valid_out && (state_q != StWait)) begin
            stray_d = 1'b1;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign valid_in  = (state_q == StIssue);
    assign rsp_valid = (state_q == StResp);
    assign a         = a_q;
    assign b         = b_q;
    assign cin       = cin_q;
    assign ctl       = ctl_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;
    // The tag counter only advances on the response handshake.
    assign rsp_tag   = tag_q;
    assign stray     = stray_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer: an ALU stub with programmable latency plus a
// transaction-level model of expected responses, tags, carry chain and latency.
module tb_alu_issuer;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_op, cmd_a, cmd_b;
    logic       cmd_cin, cmd_chain;
    logic       valid_in;
    logic [3:0] a, b, ctl;
    logic       cin;
    logic       valid_out;
    logic [3:0] alu;
    logic       carry, zero;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry, rsp_zero, rsp_err;
    logic [3:0] rsp_tag;
    logic       stray;

    int total = 0;
    int bad = 0;

    alu_issuer #(.WIDTH(4), .TIMEOUT(TIMEOUT), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_chain(cmd_chain),
        .valid_in(valid_in), .a(a), .b(b), .cin(cin), .ctl(ctl),
        .valid_out(valid_out), .alu(alu), .carry(carry), .zero(zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .rsp_tag(rsp_tag), .stray(stray)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {carry, result}.
    function automatic logic [4:0] ref_alu(input int op, input int x, input int y, input int ci);
        int r;
        int c;
        r = 0;
        c = 0;
        case (op)
            0:  r = x;
            1:  begin r = x + 1; c = (r > 15) ? 1 : 0; end
            2:  begin r = x - 1; c = (x == 0) ? 1 : 0; end
            3:  begin r = x + y; c = (r > 15) ? 1 : 0; end
            4:  begin r = x + y + ci; c = (r > 15) ? 1 : 0; end
            5:  begin r = x - y; c = (x < y) ? 1 : 0; end
            6:  begin r = x - y - ci; c = (x < y + ci) ? 1 : 0; end
            7:  r = x & y;
            8:  r = x | y;
            9:  r = x ^ y;
            10: begin r = x << 1; c = (x >> 3) & 1; end
            11: begin r = x >> 1; c = x & 1; end
            12: begin r = (x << 1) | (x >> 3); c = (x >> 3) & 1; end
            13: begin r = (x >> 1) | ((x & 1) << 3); c = x & 1; end
            default: r = 0;
        endcase
        r = r & 15;
        return {c[0], r[3:0]};
    endfunction

    // ALU stub: stub_lat cycles after the strobe, 0 = never answers.
    int         stub_lat = 1;
    int         pend_cnt = 0;
    logic [4:0] pend_res = '0;
    logic       inject = 1'b0;

    always @(posedge clk) begin
        if (valid_in && stub_lat != 0) begin
            pend_cnt <= stub_lat;
            pend_res <= ref_alu(int'(ctl), int'(a), int'(b), int'(cin));
        end else if (pend_cnt > 0) begin
            pend_cnt <= pend_cnt - 1;
        end
    end

    assign valid_out = (pend_cnt == 1) || inject;
    assign alu       = pend_res[3:0];
    assign carry     = pend_res[4];
    assign zero      = (pend_res[3:0] == 4'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Transaction model state.
    int   m_tag = 0;
    logic m_carry = 1'b0;
    // Last observed issue/response, for directed constant checks.
    logic       iss_cin;
    logic [3:0] obs_data;
    logic       obs_carry;
    logic [3:0] obs_tag;

    task automatic run_cmd(input int op, input int x, input int y, input logic ci,
                           input logic chain, input int lat, input int hold);
        logic       cin_eff, legal, e_err, e_c, e_z, busy_ok, stable_ok;
        logic [3:0] e_d;
        logic [4:0] r;
        int         e_lat, k, pulses;
        logic [3:0] iss_a, iss_b, iss_ctl;
        cin_eff = chain ? m_carry : ci;
        legal   = (op <= 13);
        e_d = '0; e_c = 1'b0; e_z = 1'b0; e_err = 1'b1;
        if (!legal) begin
            e_lat = 1;
        end else if (lat == 0) begin
            e_lat = 2 + TIMEOUT;
        end else begin
            r = ref_alu(op, x, y, int'(cin_eff));
            e_d = r[3:0]; e_c = r[4]; e_z = (r[3:0] == 4'd0); e_err = 1'b0;
            e_lat = 2 + lat;
            if (op >= 3 && op <= 6) m_carry = r[4];
        end

        check("ready_idle", 32'(cmd_ready), 32'd1);
        stub_lat  = lat;
        cmd_op    = 4'(op);
        cmd_a     = 4'(x);
        cmd_b     = 4'(y);
        cmd_cin   = ci;
        cmd_chain = chain;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 1; pulses = 0; busy_ok = 1'b1;
        iss_a = '0; iss_b = '0; iss_ctl = '0; iss_cin = 1'b0;
        while (!rsp_valid && k < 40) begin
            if (valid_in) begin
                pulses++;
                iss_a = a; iss_b = b; iss_ctl = ctl; iss_cin = cin;
            end
            if (cmd_ready) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        check("rsp_latency", 32'(k), 32'(e_lat));
        check("ready_busy", 32'(busy_ok && !cmd_ready), 32'd1);
        check("strobes", 32'(pulses), legal ? 32'd1 : 32'd0);
        if (legal) begin
            check("issue_ops", {20'd0, iss_ctl, iss_a, iss_b}, {20'd0, 4'(op), 4'(x), 4'(y)});
            check("issue_cin", 32'(iss_cin), 32'(cin_eff));
            check("alu_hold", {20'd0, ctl, a, b}, {20'd0, 4'(op), 4'(x), 4'(y)});
        end
        check("rsp_fields", {25'd0, rsp_err, rsp_carry, rsp_zero, rsp_data},
              {25'd0, e_err, e_c, e_z, e_d});
        check("rsp_tag", 32'(rsp_tag), 32'(m_tag & 15));
        obs_data = rsp_data; obs_carry = rsp_carry; obs_tag = rsp_tag;

        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || cmd_ready || rsp_data !== e_d || rsp_carry !== e_c ||
                rsp_zero !== e_z || rsp_err !== e_err || rsp_tag !== 4'(m_tag))
                stable_ok = 1'b0;
        end
        if (hold > 0) check("rsp_stable", 32'(stable_ok), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("back_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);
        m_tag++;
    endtask

    initial begin
        reset = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cmd_cin = 1'b0; cmd_chain = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("reset_outs", {14'd0, valid_in, a, b, cin, ctl, rsp_valid, rsp_data,
              rsp_carry, rsp_zero, rsp_err, stray}, 32'd0);
        check("reset_tag", 32'(rsp_tag), 32'd0);
        check("reset_ready", 32'(cmd_ready), 32'd1);

        run_cmd(3, 9, 8, 1'b0, 1'b0, 1, 0);
        check("add_const", {27'd0, obs_carry, obs_data}, 32'h11);
        run_cmd(4, 0, 0, 1'b0, 1'b1, 1, 0);
        check("addc_chain_cin", 32'(iss_cin), 32'd1);
        check("addc_const", {23'd0, obs_tag, obs_carry, obs_data}, 32'h21);
        run_cmd(4, 0, 0, 1'b1, 1'b1, 1, 0);
        check("addc_chain_cin0", 32'(iss_cin), 32'd0);

        run_cmd(3, 15, 1, 1'b0, 1'b0, 1, 0);
        run_cmd(14, 3, 3, 1'b0, 1'b0, 1, 0);
        run_cmd(4, 0, 0, 1'b0, 1'b1, 1, 0);
        check("carry_kept", 32'(iss_cin), 32'd1);
        run_cmd(15, 1, 1, 1'b1, 1'b0, 1, 1);
        run_cmd(9, 5, 12, 1'b0, 1'b0, 0, 0);
        run_cmd(5, 3, 5, 1'b0, 1'b0, 1, 5);
        check("sub_const", {27'd0, obs_carry, obs_data}, 32'h1E);
        run_cmd(6, 7, 2, 1'b1, 1'b0, TIMEOUT, 0);

        for (int n = 0; n < 40; n++) begin
            int lat;
            lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), lat, int'($urandom_range(0, 2)));
        end
        check("no_stray", 32'(stray), 32'd0);

        // Reset while waiting on a silent ALU.
        stub_lat = 0;
        cmd_op = 4'd3; cmd_a = 4'd1; cmd_b = 4'd2; cmd_chain = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_tag = 0;
        m_carry = 1'b0;
        check("midrst_outs", {14'd0, valid_in, a, b, cin, ctl, rsp_valid, rsp_data,
              rsp_carry, rsp_zero, rsp_err, stray}, 32'd0);
        check("midrst_tag_ready", {27'd0, rsp_tag, cmd_ready}, 32'd1);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_set", {29'd0, stray, rsp_valid, cmd_ready}, 32'd5);
        run_cmd(4, 2, 3, 1'b1, 1'b1, 1, 0);
        check("post_rst_cin", 32'(iss_cin), 32'd0);
        check("post_rst_tag", 32'(obs_tag), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
